uart_tx: RTL and testbench

- RS-232 style serial transmitter: 8 data bits, LSB first, 1 start bit, 1 stop bit (8N1), idle-high line.
- Companion to the 8N1 receiver. Bit period is `t_rate` clocks, the same parameter meaning and default the receiver uses, so TX and RX built from one parameter value interoperate.
- Host side is a simple valid/ready byte handshake. Line side is a single serial output.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side byte handshake plus serial line of the 8N1 transmitter.
//   tx_data  [7:0] byte to send, sampled only on the accept cycle
//   tx_start       send request, level or pulse
//   tx_ready       transmitter idle, a tx_start is accepted this cycle
//   busy           frame on the line
//   done           one-cycle pulse after the stop bit completes
//   Rs232_tx       serial line, idle high
// master = host side, slave = transmitter side.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       Rs232_tx;

  modport master (output tx_data, tx_start,
                  input  tx_ready, busy, done, Rs232_tx);
  modport slave  (input  tx_data, tx_start,
                  output tx_ready, busy, done, Rs232_tx);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: RS-232 8N1 serial transmitter, LSB first, idle-high line.
// Ports:
//   clk     system clock, rising edge
//   Rst_tx  asynchronous active-low reset
//   bus     uart_tx_if.slave (tx_data/tx_start in; tx_ready/busy/done/Rs232_tx out)
// Parameter t_rate: clocks per bit (4..8191), 13-bit baud counter.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit (11-bit frame).
module uart_tx #(
  parameter int t_rate = 5208
) (
  input  logic     clk,
  input  logic     Rst_tx,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t      state_q;
  logic [12:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        line_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic [12:0] baud_d;
  logic        baud_end;

  assign baud_d   = baud_q + 13'd1;
  assign baud_end = (baud_q == 13'(t_rate - 1));

  // The line is driven one register ahead: each transition loads the level
  // of the bit being entered, so the output never lags the state.
  always_ff @(posedge clk or negedge Rst_tx) begin
    if (!Rst_tx) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (bus.tx_start) begin
            shift_q <= bus.tx_data;
            state_q <= START;
            line_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^bus.tx_data;
`endif
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            line_q  <= shift_q[0];
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              line_q  <= par_q;
`else
              state_q <= STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              line_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= STOP;
            line_q  <= 1'b1;
          end else begin
            baud_q <= baud_d;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= IDLE;
            line_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            baud_q <= baud_d;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          line_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Rs232_tx = line_q;
  assign bus.done     = done_q;
  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with t_rate = 16.
module tb_uart_tx;
  localparam int TR = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic Rst_tx;
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0;
  int   t_low, d0;
  logic [7:0] pats [6] = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'hFE, 8'h7F};

  uart_tx_if bus();
  uart_tx #(.t_rate(TR)) dut (.clk(clk), .Rst_tx(Rst_tx), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      prev_done = last_done;
      last_done = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first low cycle; walks the whole frame cycle by cycle and
  // ends in the done cycle. inj >= 0 pulses a 0x3C request at that cycle
  // offset; scr scrambles tx_data every cycle.
  task automatic check_frame(input logic [7:0] d, input string tag, input int inj, input bit scr);
    logic exp_b;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)      exp_b = 1'b0;
      else if (b <= 8) exp_b = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == 9) exp_b = ^d;
`endif
      else             exp_b = 1'b1;
      for (int c = 0; c < TR; c++) begin
        chk($sformatf("%s line b%0d c%0d", tag, b, c), 32'(bus.Rs232_tx), 32'(exp_b));
        chk($sformatf("%s flags b%0d c%0d", tag, b, c),
            32'({bus.busy, bus.tx_ready, bus.done}), 32'(3'b100));
        if (b*TR + c == inj) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = 8'h3C;
        end else if (inj >= 0) begin
          bus.tx_start = 1'b0;
        end
        if (scr) bus.tx_data = 8'($urandom);
        tick();
      end
    end
    chk({tag, " done cycle"},
        32'({bus.busy, bus.tx_ready, bus.done, bus.Rs232_tx}), 32'(4'b0111));
  endtask

  task automatic start(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    t_low = cyc;
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    Rst_tx = 1'b1;
    #2 Rst_tx = 1'b0;
    #1;
    chk("reset values", 32'({bus.Rs232_tx, bus.busy, bus.done, bus.tx_ready}), 32'(4'b1001));
    repeat (2) @(posedge clk);
    @(negedge clk) Rst_tx = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("idle after reset", 32'({bus.Rs232_tx, bus.busy, bus.tx_ready, bus.done}), 32'(4'b1010));
      tick();
    end

    // Single byte 0xA5
    start(8'hA5);
    check_frame(8'hA5, "a5", -1, 1'b0);
    tick();
    chk("a5 frame length", 32'(last_done - t_low), 32'(NB*TR));
    chk("a5 after done", 32'({bus.Rs232_tx, bus.done}), 32'(2'b10));

    // Request during a frame is ignored
    d0 = done_cnt;
    start(8'hFF);
    check_frame(8'hFF, "ff", 40, 1'b0);
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("ff no second frame", 32'({bus.Rs232_tx, bus.busy, bus.tx_ready, bus.done}), 32'(4'b1010));
      tick();
    end
    chk("ff single done", 32'(done_cnt - d0), 32'd1);

    // Data stability after accept
    start(8'h55);
    check_frame(8'h55, "55", -1, 1'b1);
    tick();

    // Back-to-back with tx_start held high
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_data = 8'h81;
    check_frame(8'h00, "b2b0", -1, 1'b0);
    tick();
    bus.tx_start = 1'b0;
    check_frame(8'h81, "b2b1", -1, 1'b0);
    tick();
    chk("b2b done spacing", 32'(last_done - prev_done), 32'(NB*TR + 1));

    // Pattern sweep
    for (int i = 0; i < 6; i++) begin
      start(pats[i]);
      check_frame(pats[i], $sformatf("pat%0d", i), -1, 1'b0);
      tick();
    end

`ifdef UART_TX_PARITY_EN
    start(8'h07);
    repeat (9*TR + 8) tick();
    chk("par 07 bit", 32'(bus.Rs232_tx), 32'd1);
    repeat (2*TR - 8) tick();
    chk("par 07 done", 32'(bus.done), 32'd1);
    tick();
    chk("par 07 frame len", 32'(last_done - t_low), 32'd176);
    start(8'h03);
    repeat (9*TR + 8) tick();
    chk("par 03 bit", 32'(bus.Rs232_tx), 32'd0);
    repeat (2*TR - 8) tick();
    chk("par 03 done", 32'(bus.done), 32'd1);
    tick();
`endif

    // Reset mid-frame
    start(8'h00);
    repeat (40) tick();
    chk("mid-frame line low", 32'(bus.Rs232_tx), 32'd0);
    #2 Rst_tx = 1'b0;
    #1;
    chk("async reset", 32'({bus.Rs232_tx, bus.busy, bus.done, bus.tx_ready}), 32'(4'b1001));
    @(negedge clk) Rst_tx = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("idle after abort", 32'({bus.Rs232_tx, bus.busy, bus.tx_ready, bus.done}), 32'(4'b1010));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
